// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//   Packs a byte stream into 32-bit words. Both sides use a valid/ready
//   handshake. The word output is a single register, and a flush request
//   sends out a partially filled word.
//
//   Parameter
//     LSB_FIRST   1: the first byte of a word lands in word_out[7:0]
//                 0: the first byte of a word lands in word_out[31:24]
//
//   Optional build macro
//     NIBBLE_SWAP_EN  When defined, each accepted byte is stored with its
//                     two nibbles exchanged. This adds no latency.
//
//   Ports
//     clk         in   rising-edge clock
//     rst_n       in   synchronous reset, active-low
//     byte_in     in   [7:0] input byte
//     byte_valid  in   byte_in is valid
//     byte_ready  out  the packer accepts byte_in this cycle
//     flush       in   one-cycle pulse that sends out the current partial word
//     word_out    out  [31:0] assembled word
//     word_bytes  out  [2:0] number of valid bytes in word_out (1..4)
//     word_valid  out  word_out and word_bytes are valid
//     word_ready  in   the consumer accepts word_out this cycle
// -----------------------------------------------------------------------------
module byte_word_packer #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic [2:0]  word_bytes,
    output logic        word_valid,
    input  logic        word_ready
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  bytes_q, bytes_d;
    logic        valid_q, valid_d;
    logic        pend_q, pend_d;

    logic [7:0]  byte_st;
    logic [1:0]  lane_sel;
    logic [31:0] acc_with;
    logic [2:0]  cnt_with;
    logic        out_free;
    logic        byte_fire;
    logic        word_full;
    logic        flush_req;
    logic        load;

`ifdef NIBBLE_SWAP_EN
    assign byte_st = {byte_in[3:0], byte_in[7:4]};
`else
    assign byte_st = byte_in;
`endif

    // The output register can take a new word when it is empty or when it
    // is being drained in this cycle.
    assign out_free = !valid_q || word_ready;

    // Stall only on a 4th byte that has nowhere to go, or while a flush waits
    // for the output register. rst_n is included so that byte_ready is low
    // during the reset cycle itself.
    assign byte_ready = rst_n && !pend_q
                        && !(cnt_q == 2'd3 && valid_q && !word_ready);
    assign byte_fire  = byte_valid && byte_ready;

    assign lane_sel = (LSB_FIRST != 0) ? cnt_q : (2'd3 - cnt_q);

    // Accumulator view that already includes this cycle's byte, so a
    // completing byte or a coincident flush is loaded with no extra cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign acc_with[8*gi +: 8] = (byte_fire && lane_sel == 2'(gi))
                                         ? byte_st : acc_q[8*gi +: 8];
        end
    endgenerate

    assign cnt_with  = {1'b0, cnt_q} + {2'b00, byte_fire};
    assign word_full = (cnt_with == 3'd4);

    // A full word takes precedence, so a flush that arrives with the 4th byte
    // has no further effect. An empty accumulator is never flushed.
    assign flush_req = (flush || pend_q) && !word_full && (cnt_with != 3'd0);

    // word_full implies out_free, because byte_ready blocks a 4th byte
    // when the output register is held.
    assign load = word_full || (flush_req && out_free);

    always_comb begin
        cnt_d   = load ? 2'd0 : cnt_with[1:0];
        acc_d   = load ? 32'd0 : acc_with;
        word_d  = load ? acc_with : word_q;
        bytes_d = load ? cnt_with : bytes_q;
        valid_d = load || (valid_q && !word_ready);
        pend_d  = flush_req && !out_free;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            acc_q   <= 32'd0;
            word_q  <= 32'd0;
            bytes_q <= 3'd0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign word_out   = word_q;
    assign word_bytes = bytes_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_word_packer
//   Runs two packers side by side (LSB_FIRST=1 and LSB_FIRST=0) on the same
//   stimulus. A queue-based model computes the expected handshake and word
//   values, and the outputs are compared on every falling edge. Directed
//   sections check literal words against known results.
// -----------------------------------------------------------------------------
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;

    logic        byte_ready_l, byte_ready_m;
    logic        word_valid_l, word_valid_m;
    logic [31:0] word_out_l, word_out_m;
    logic [2:0]  word_bytes_l, word_bytes_m;

    always #5 clk = ~clk;

    byte_word_packer #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_l), .flush(flush), .word_out(word_out_l),
        .word_bytes(word_bytes_l), .word_valid(word_valid_l), .word_ready(word_ready)
    );

    byte_word_packer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_m), .flush(flush), .word_out(word_out_m),
        .word_bytes(word_bytes_m), .word_valid(word_valid_m), .word_ready(word_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] part[$];   // bytes accepted into the current word, in arrival order
    logic [7:0] outb[$];   // bytes held in the output word
    bit         m_valid = 1'b0;
    bit         m_pend  = 1'b0;
    bit         m_fire;

    typedef struct {
        logic [31:0] wl;
        logic [31:0] wm;
        int          n;
    } drain_t;
    drain_t dlog[$];

    function automatic logic [7:0] nswap(input logic [7:0] b);
`ifdef NIBBLE_SWAP_EN
        return {b[3:0], b[7:4]};
`else
        return b;
`endif
    endfunction

    // Expected form of a literal plain-byte word in the current build.
    function automatic logic [31:0] lit(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (32'(nswap(8'(w >> (8*i)))) << (8*i));
        return r;
    endfunction

    // Byte i goes to byte position i (lsb order) or 3-i (msb order).
    function automatic logic [31:0] pack_out(input bit lsb);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < outb.size(); i++)
            w = w | (32'(outb[i]) << (lsb ? 8*i : 8*(3-i)));
        return w;
    endfunction

    function automatic bit m_ready();
        return rst_n && !m_pend && !(part.size() == 3 && m_valid && !word_ready);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            part.delete();
            outb.delete();
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else begin
            m_fire = byte_valid && m_ready();
            if (m_valid && word_ready) begin
                dlog.push_back('{wl: pack_out(1'b1), wm: pack_out(1'b0), n: outb.size()});
                $display("word %0d drained lsb=%h msb=%h bytes=%0d",
                         dlog.size(), pack_out(1'b1), pack_out(1'b0), outb.size());
                m_valid = 1'b0;
            end
            if (m_fire) part.push_back(nswap(byte_in));
            if (part.size() == 4) begin
                outb = part;
                part.delete();
                m_valid = 1'b1;
            end else if ((flush || m_pend) && part.size() > 0) begin
                if (!m_valid) begin
                    outb = part;
                    part.delete();
                    m_valid = 1'b1;
                    m_pend  = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("byte_ready_l", 32'(byte_ready_l), 32'(m_ready()));
        chk("byte_ready_m", 32'(byte_ready_m), 32'(m_ready()));
        chk("word_valid_l", 32'(word_valid_l), 32'(m_valid));
        chk("word_valid_m", 32'(word_valid_m), 32'(m_valid));
        if (m_valid) begin
            chk("word_out_l", word_out_l, pack_out(1'b1));
            chk("word_out_m", word_out_m, pack_out(1'b0));
            chk("word_bytes_l", 32'(word_bytes_l), 32'(outb.size()));
            chk("word_bytes_m", 32'(word_bytes_m), 32'(outb.size()));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] src[64];
    int         idx;
    int         base;

    // Runs ncyc cycles and offers src[idx..n-1] in order. word_ready stays
    // low for the first `hold` cycles. rnd adds random gaps, stalls and flushes.
    task automatic run(input int n, input int hold, input bit rnd, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bit acc;
            word_ready = (c >= hold) && (!rnd || $urandom_range(0, 3) != 0);
            byte_valid = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
            byte_in    = (idx < n) ? src[idx] : 8'h00;
            flush      = rnd && ($urandom_range(0, 11) == 0);
            acc        = byte_valid && m_ready();
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic pulse_flush(input bit wr);
        word_ready = wr;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready_l), 32'd0);
        chk({tag, "_word_valid"}, 32'(word_valid_l), 32'd0);
        chk({tag, "_word_out"},   word_out_l, 32'd0);
        chk({tag, "_word_bytes"}, 32'(word_bytes_l), 32'd0);
        chk({tag, "_word_out_m"}, word_out_m, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 11,22,33,44 back-to-back
        idx = 0; base = dlog.size();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        run(4, 0, 1'b0, 4);
        chk("t1_valid_after_4th", 32'(word_valid_l), 32'd1);
        chk("t1_bytes", 32'(word_bytes_l), 32'd4);
        run(4, 0, 1'b0, 2);
        chk("t1_count", 32'(dlog.size()), 32'(base + 1));
        chk("t1_lsb", dlog[base].wl, lit(32'h44332211));
        chk("t1_msb", dlog[base].wm, lit(32'h11223344));

        // 01..08 with no stall
        idx = 0; base = dlog.size();
        for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
        run(8, 0, 1'b0, 8);
        chk("t2_no_stall", 32'(idx), 32'd8);
        run(8, 0, 1'b0, 2);
        chk("t2_msb0", dlog[base].wm, lit(32'h01020304));
        chk("t2_msb1", dlog[base + 1].wm, lit(32'h05060708));

        // 12 bytes while the consumer is stalled
        idx = 0; base = dlog.size();
        for (int i = 0; i < 12; i++) src[i] = 8'(i + 1);
        run(12, 100, 1'b0, 12);
        chk("t3_accepted_held", 32'(idx), 32'd7);
        chk("t3_ready_low", 32'(byte_ready_l), 32'd0);
        run(12, 0, 1'b0, 20);
        chk("t3_all_accepted", 32'(idx), 32'd12);
        chk("t3_count", 32'(dlog.size()), 32'(base + 3));
        chk("t3_w0", dlog[base].wl, lit(32'h04030201));
        chk("t3_w1", dlog[base + 1].wl, lit(32'h08070605));
        chk("t3_w2", dlog[base + 2].wl, lit(32'h0C0B0A09));

        // Partial flush, then a flush with an empty accumulator
        idx = 0; base = dlog.size();
        src[0] = 8'hAA; src[1] = 8'hBB;
        run(2, 0, 1'b0, 2);
        pulse_flush(1'b1);
        run(2, 0, 1'b0, 3);
        chk("t4_count", 32'(dlog.size()), 32'(base + 1));
        chk("t4_lsb", dlog[base].wl, lit(32'h0000BBAA));
        chk("t4_msb", dlog[base].wm, lit(32'hAABB0000));
        chk("t4_n", 32'(dlog[base].n), 32'd2);
        base = dlog.size();
        pulse_flush(1'b1);
        run(0, 0, 1'b0, 3);
        chk("t4_empty_flush", 32'(dlog.size()), 32'(base));

        // Flush that waits behind a held word
        idx = 0; base = dlog.size();
        for (int i = 0; i < 6; i++) src[i] = 8'(i + 1);
        run(6, 100, 1'b0, 6);
        pulse_flush(1'b0);
        chk("t4b_pending_ready", 32'(byte_ready_l), 32'd0);
        run(6, 0, 1'b0, 4);
        chk("t4b_w0", dlog[base].wl, lit(32'h04030201));
        chk("t4b_w1", dlog[base + 1].wl, lit(32'h00000605));
        chk("t4b_n1", 32'(dlog[base + 1].n), 32'd2);

        // Reset in the middle of a word
        idx = 0; base = dlog.size();
        src[0] = 8'h99; src[1] = 8'h98; src[2] = 8'h97;
        run(3, 0, 1'b0, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        idx = 0;
        for (int i = 0; i < 4; i++) src[i] = 8'(i + 1);
        run(4, 0, 1'b0, 6);
        chk("t5_count", 32'(dlog.size()), 32'(base + 1));
        chk("t5_lsb", dlog[base].wl, lit(32'h04030201));

        // Nibble-order check
        idx = 0; base = dlog.size();
        src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'h56; src[3] = 8'h78;
        run(4, 0, 1'b0, 6);
`ifdef NIBBLE_SWAP_EN
        chk("t6_nibble", dlog[base].wl, 32'h87654321);
`else
        chk("t6_plain", dlog[base].wl, 32'h78563412);
`endif

        // Random traffic with stalls, gaps and flushes
        idx = 0; base = dlog.size();
        for (int i = 0; i < 64; i++) src[i] = 8'($urandom_range(0, 255));
        run(64, 0, 1'b1, 800);
        chk("t7_all_accepted", 32'(idx), 32'd64);
        pulse_flush(1'b1);
        run(64, 0, 1'b0, 6);
        begin
            int k;
            k = 0;
            for (int w = base; w < dlog.size(); w++) begin
                for (int j = 0; j < dlog[w].n; j++) begin
                    if (k < 64) chk("t7_order", 32'(8'(dlog[w].wl >> (8*j))), 32'(nswap(src[k])));
                    k++;
                end
            end
            chk("t7_total_bytes", 32'(k), 32'd64);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
